// File: rtl/fw_pkg.sv
// Shared defaults and readback layout for the DNN event toggle generator.
package fw_pkg;

    localparam int DNN_SYNC_STAGES    = 2;
    localparam int DNN_FILTER_CYCLES  = 2;
    localparam int DNN_HOLDOFF_CYCLES = 0;
    localparam int DNN_CNT_WIDTH      = 16;

    // Per-channel readback register image
    typedef struct packed {
        logic                     toggle;
        logic                     pulse;
        logic [DNN_CNT_WIDTH-1:0] cnt;
        logic                     sat;
    } dnn_chan_t;

endpackage

// File: rtl/dnn_chan_cond.sv
// One channel: synchronizer, glitch filter, holdoff, event toggle/pulse and
// saturating event counter.
module dnn_chan_cond
    import fw_pkg::*;
#(
    parameter int SYNC_STAGES    = DNN_SYNC_STAGES,
    parameter int FILTER_CYCLES  = DNN_FILTER_CYCLES,
    parameter int HOLDOFF_CYCLES = DNN_HOLDOFF_CYCLES,
    parameter int CNT_WIDTH      = DNN_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pin_i,
    input  logic                 enable_i,
    input  logic                 clr_i,
    output logic                 toggle_o,
    output logic                 pulse_o,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 sat_o
);

    localparam int MW = $clog2(FILTER_CYCLES + 1);
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f_q, f_d;
    logic [MW-1:0]          m_q, m_d;
    logic [HW-1:0]          h_q, h_d;
    logic                   toggle_q, pulse_q, sat_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   evt;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        f_d = f_q;
        m_d = m_q;
        if (s == f_q) begin
            m_d = '0;
        end else if (m_q == MW'(FILTER_CYCLES - 1)) begin
            f_d = s;
            m_d = '0;
        end else begin
            m_d = m_q + 1'b1;
        end
    end

    // Only a 0->1 acceptance outside the dead time counts; blocked edges are dropped.
    assign evt = f_d & ~f_q & enable_i & (h_q == '0);

    always_comb begin
        h_d = h_q;
        if (evt)
            h_d = HW'(HOLDOFF_CYCLES);
        else if (h_q != '0)
            h_d = h_q - 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (evt && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            f_q      <= 1'b0;
            m_q      <= '0;
            h_q      <= '0;
            toggle_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_i};
            f_q      <= f_d;
            m_q      <= m_d;
            h_q      <= h_d;
            toggle_q <= toggle_q ^ evt;
            pulse_q  <= evt;
            cnt_q    <= cnt_d;
            // Counter holds at all-ones until cleared, so this stays sticky.
            sat_q    <= &cnt_d;
        end
    end

    assign toggle_o = toggle_q;
    assign pulse_o  = pulse_q;
    assign cnt_o    = cnt_q;
    assign sat_o    = sat_q;

endmodule

// File: rtl/dnn_event_toggle_gen.sv
// Turns the two async DNN result pins into up/dn event toggles, pulses and
// saturating counters for the firmware top.
module dnn_event_toggle_gen
    import fw_pkg::*;
#(
    parameter int SYNC_STAGES    = DNN_SYNC_STAGES,
    parameter int FILTER_CYCLES  = DNN_FILTER_CYCLES,
    parameter int HOLDOFF_CYCLES = DNN_HOLDOFF_CYCLES,
    parameter int CNT_WIDTH      = DNN_CNT_WIDTH
) (
    input  logic                 S_AXI_ACLK,
    input  logic                 S_AXI_ARESETN,
    input  logic                 dnn_output_0,
    input  logic                 dnn_output_1,
    input  logic                 enable,
    input  logic                 cnt_clear,
    output logic                 up_event_toggle,
    output logic                 dn_event_toggle,
    output logic                 up_event_pulse,
    output logic                 dn_event_pulse,
    output logic [CNT_WIDTH-1:0] up_event_cnt,
    output logic [CNT_WIDTH-1:0] dn_event_cnt,
    output logic                 up_cnt_sat,
    output logic                 dn_cnt_sat
);

    dnn_chan_cond #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_up (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .pin_i   (dnn_output_0),
        .enable_i(enable),
        .clr_i   (cnt_clear),
        .toggle_o(up_event_toggle),
        .pulse_o (up_event_pulse),
        .cnt_o   (up_event_cnt),
        .sat_o   (up_cnt_sat)
    );

    dnn_chan_cond #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_dn (
        .clk_i   (S_AXI_ACLK),
        .rst_ni  (S_AXI_ARESETN),
        .pin_i   (dnn_output_1),
        .enable_i(enable),
        .clr_i   (cnt_clear),
        .toggle_o(dn_event_toggle),
        .pulse_o (dn_event_pulse),
        .cnt_o   (dn_event_cnt),
        .sat_o   (dn_cnt_sat)
    );

endmodule
